// File: rtl/usb_rst_sequencer_if.sv
// rtl/usb_rst_sequencer_if.sv - request/status signals between PIO and the USB reset sequencer
interface usb_rst_sequencer_if;
  logic       rst_req;
  logic       usb_rst_n;
  logic       usb_ready;
  logic       ready_irq;
  logic [7:0] pulse_count;

  modport master (
    output rst_req,
    input  usb_rst_n,
    input  usb_ready,
    input  ready_irq,
    input  pulse_count
  );

  modport slave (
    input  rst_req,
    output usb_rst_n,
    output usb_ready,
    output ready_irq,
    output pulse_count
  );
endinterface

// File: rtl/usb_rst_sequencer.sv
// rtl/usb_rst_sequencer.sv - timed USB controller reset with minimum pulse and recovery window
module usb_rst_sequencer #(
  parameter int PULSE_CYCLES   = 500,
  parameter int RECOVER_CYCLES = 5000,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  usb_rst_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RECOVER,
    ST_READY
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rst_q;
  logic             rise;
  logic             usb_rst_n_q;
  logic             usb_ready_q;
  logic             ready_irq_q;
  logic             irq_nxt;
  logic [7:0]       pulse_count_q, pulse_count_nxt;

  assign rise            = bus.rst_req & ~rst_q;
  assign bus.usb_rst_n   = usb_rst_n_q;
  assign bus.usb_ready   = usb_ready_q;
  assign bus.ready_irq   = ready_irq_q;
  assign bus.pulse_count = pulse_count_q;

  // Outputs are registered from the next state so a rise at edge N pulls usb_rst_n low at N+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_ASSERT;
      cnt           <= '0;
      rst_q         <= 1'b0;
      usb_rst_n_q   <= 1'b0;
      usb_ready_q   <= 1'b0;
      ready_irq_q   <= 1'b0;
      pulse_count_q <= 8'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rst_q         <= bus.rst_req;
      usb_rst_n_q   <= (state_nxt != ST_ASSERT);
      usb_ready_q   <= (state_nxt == ST_READY);
      ready_irq_q   <= irq_nxt;
      pulse_count_q <= pulse_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    irq_nxt         = 1'b0;
    pulse_count_nxt = pulse_count_q;
    case (state)
      ST_ASSERT: begin
        if (rise) begin
          cnt_nxt = '0;
        end else if (cnt == PULSE_LAST) begin
          // Counter parks here until the request level drops.
          if (!bus.rst_req) begin
            state_nxt = ST_RECOVER;
            cnt_nxt   = '0;
            if (pulse_count_q != 8'hff) begin
              pulse_count_nxt = pulse_count_q + 8'd1;
            end
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RECOVER: begin
        if (rise) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
        end else if (cnt == RECOVER_LAST) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
          irq_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (rise) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
